// File: rtl/timer_requester_pkg.sv
// rtl/timer_requester_pkg.sv - shared llct codes, state and error encodings for the timer requester
package timer_requester_pkg;

    localparam logic [7:0] LLCT_NOP  = 8'h00;
    localparam logic [7:0] TIME_OP   = 8'h01;
    localparam logic [7:0] LLCT_IO   = 8'h02;

    localparam int CNT_W_DEFAULT     = 8;
    localparam int WD_MARGIN_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_WATCHDOG = 2'b01,
        ERR_ABORT    = 2'b10
    } err_t;

endpackage

// File: rtl/timer_requester_if.sv
// rtl/timer_requester_if.sv - executor-side command/report bundle of the timer requester
interface timer_requester_if #(
    parameter int CNT_W = 8
);
    logic             llc_valid;
    logic [7:0]       llct;
    logic [CNT_W-1:0] llcc;
    logic             abort;
    logic             busy;
    logic             llc_done;
    logic             llc_error;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] elapsed;

    modport master (
        output llc_valid, llct, llcc, abort,
        input  busy, llc_done, llc_error, err_code, elapsed
    );

    modport slave (
        input  llc_valid, llct, llcc, abort,
        output busy, llc_done, llc_error, err_code, elapsed
    );
endinterface

// File: rtl/timer_requester_tick_counter.sv
// rtl/timer_requester_tick_counter.sv - saturating enable counter with clear and greater-than compare
module timer_requester_tick_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         en,
    input  logic [W:0]   limit,
    output logic [W-1:0] count,
    output logic         gt
);
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

    // limit is one bit wider so callers can add a margin without wrapping
    assign gt = ({1'b0, count} > limit);
endmodule

// File: rtl/timer_requester.sv
// rtl/timer_requester.sv - holds the timer run request for a time command, with watchdog and abort
module timer_requester
    import timer_requester_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEFAULT,
    parameter int WD_MARGIN = WD_MARGIN_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_10hz,
    input  logic              timeout,
    output logic              timer_run_n,
    timer_requester_if.slave  exec
);
    state_t           state;
    logic [CNT_W-1:0] cnt_target;
    logic [CNT_W:0]   wd_limit;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_en;
    logic             wd_gt;

    assign accept   = exec.llc_valid && (exec.llct == TIME_OP);
    assign cnt_clr  = (state == ST_IDLE) && accept;
    assign cnt_en   = (state == ST_WAIT) && tick_10hz;
    assign wd_limit = {1'b0, cnt_target} + (CNT_W+1)'(WD_MARGIN);

    timer_requester_tick_counter #(.W(CNT_W)) u_tick_counter (
        .clk    (clk),
        .resetn (reset),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .limit  (wd_limit),
        .count  (exec.elapsed),
        .gt     (wd_gt)
    );

    // Outputs are set on the edge that enters each state, so they track state with no comb path.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_IDLE;
            cnt_target     <= '0;
            timer_run_n    <= 1'b1;
            exec.busy      <= 1'b0;
            exec.llc_done  <= 1'b0;
            exec.llc_error <= 1'b0;
            exec.err_code  <= ERR_NONE;
        end else begin
            exec.llc_done  <= 1'b0;
            exec.llc_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        exec.err_code <= ERR_NONE;
                        if (exec.llcc != '0) begin
                            cnt_target  <= exec.llcc;
                            timer_run_n <= 1'b0;
                            exec.busy   <= 1'b1;
                            state       <= ST_ARM;
                        end else begin
                            exec.llc_done <= 1'b1;
                            state         <= ST_DONE;
                        end
                    end
                end
                // a timeout seen here belongs to a previous run and is dropped
                ST_ARM: state <= ST_WAIT;
                ST_WAIT: begin
                    if (exec.abort) begin
                        exec.err_code  <= ERR_ABORT;
                        exec.llc_error <= 1'b1;
                        timer_run_n    <= 1'b1;
                        exec.busy      <= 1'b0;
                        state          <= ST_ERR;
                    end else if (!timeout) begin
                        exec.llc_done <= 1'b1;
                        timer_run_n   <= 1'b1;
                        exec.busy     <= 1'b0;
                        state         <= ST_DONE;
                    end else if (wd_gt) begin
                        exec.err_code  <= ERR_WATCHDOG;
                        exec.llc_error <= 1'b1;
                        timer_run_n    <= 1'b1;
                        exec.busy      <= 1'b0;
                        state          <= ST_ERR;
                    end
                end
                ST_DONE, ST_ERR: state <= ST_IDLE;
                default: begin
                    timer_run_n <= 1'b1;
                    exec.busy   <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_timer_requester.sv
// tb/tb_timer_requester.sv - directed self-checking bench for timer_requester
module tb_timer_requester;
    logic clk = 1'b0;
    logic reset;
    logic tick_10hz;
    logic timeout;
    logic timer_run_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    timer_requester_if #(.CNT_W(8)) bus ();

    timer_requester dut (
        .clk         (clk),
        .reset       (reset),
        .tick_10hz   (tick_10hz),
        .timeout     (timeout),
        .timer_run_n (timer_run_n),
        .exec        (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [7:0] t, input logic [7:0] c);
        bus.llc_valid = 1'b1;
        bus.llct      = t;
        bus.llcc      = c;
        step();
        bus.llc_valid = 1'b0;
        bus.llct      = 8'hAA;
        bus.llcc      = 8'h09;
    endtask

    task automatic tick();
        tick_10hz = 1'b1;
        step();
        tick_10hz = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b0; tick_10hz = 1'b0; timeout = 1'b1;
        bus.llc_valid = 1'b0; bus.llct = 8'h00; bus.llcc = 8'h00; bus.abort = 1'b0;
        step(); step();
        check("rst_run_n", timer_run_n, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.llc_done, 0);
        check("rst_error", bus.llc_error, 0);
        check("rst_err_code", bus.err_code, 0);
        check("rst_elapsed", bus.elapsed, 0);
        reset = 1'b1;
        step();

        // normal delay of 5 ticks
        start_cmd(8'h01, 8'd5);
        check("norm_run_n_low", timer_run_n, 0);
        check("norm_busy", bus.busy, 1);
        step();
        for (int i = 0; i < 5; i++) tick();
        check("norm_elapsed", bus.elapsed, 5);
        check("norm_run_n_held", timer_run_n, 0);
        check("norm_no_err", bus.llc_error, 0);
        timeout = 1'b0;
        step();
        timeout = 1'b1;
        check("norm_done", bus.llc_done, 1);
        check("norm_run_n_high", timer_run_n, 1);
        check("norm_busy_low", bus.busy, 0);
        check("norm_err_code", bus.err_code, 0);
        step();
        check("norm_done_pulse", bus.llc_done, 0);

        // zero count
        start_cmd(8'h01, 8'd0);
        check("zero_done", bus.llc_done, 1);
        check("zero_run_n", timer_run_n, 1);
        check("zero_elapsed", bus.elapsed, 0);
        check("zero_busy", bus.busy, 0);
        step();
        check("zero_done_pulse", bus.llc_done, 0);
        check("zero_run_n_after", timer_run_n, 1);

        // watchdog: 3 + margin 2, error after the 6th tick
        start_cmd(8'h01, 8'd3);
        step();
        for (int i = 0; i < 5; i++) tick();
        check("wd_no_err_at5", bus.llc_error, 0);
        tick_10hz = 1'b1;
        step();
        tick_10hz = 1'b0;
        check("wd_elapsed6", bus.elapsed, 6);
        check("wd_no_err_yet", bus.llc_error, 0);
        step();
        check("wd_error", bus.llc_error, 1);
        check("wd_err_code", bus.err_code, 1);
        check("wd_run_n", timer_run_n, 1);
        step();
        check("wd_error_pulse", bus.llc_error, 0);
        check("wd_err_code_held", bus.err_code, 1);

        // abort and timeout in the same WAIT cycle
        start_cmd(8'h01, 8'd4);
        check("ab_err_code_clr", bus.err_code, 0);
        step();
        bus.abort = 1'b1;
        timeout   = 1'b0;
        step();
        bus.abort = 1'b0;
        timeout   = 1'b1;
        check("ab_error", bus.llc_error, 1);
        check("ab_err_code", bus.err_code, 2);
        check("ab_no_done", bus.llc_done, 0);
        step();
        check("ab_no_done_after", bus.llc_done, 0);

        // non-time command and abort in IDLE are ignored
        start_cmd(8'h02, 8'd7);
        check("nt_busy", bus.busy, 0);
        check("nt_run_n", timer_run_n, 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("idle_abort_err", bus.llc_error, 0);

        // llc_valid during a running delay neither clears elapsed nor re-latches target
        start_cmd(8'h01, 8'd3);
        step();
        tick();
        check("busy_elapsed1", bus.elapsed, 1);
        start_cmd(8'h01, 8'd9);
        check("busy_relatch_elapsed", bus.elapsed, 1);
        check("busy_still", bus.busy, 1);
        for (int i = 0; i < 5; i++) tick();
        check("busy_target_kept", bus.llc_error, 1);
        check("busy_target_code", bus.err_code, 1);
        step();

        // reset mid-WAIT
        start_cmd(8'h01, 8'd5);
        step();
        tick();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("mrst_run_n", timer_run_n, 1);
        check("mrst_busy", bus.busy, 0);
        check("mrst_elapsed", bus.elapsed, 0);
        check("mrst_err_code", bus.err_code, 0);
        check("mrst_error", bus.llc_error, 0);
        timeout = 1'b0;
        step();
        timeout = 1'b1;
        check("mrst_no_done", bus.llc_done, 0);
        step();
        check("mrst_no_done2", bus.llc_done, 0);
        check("mrst_run_n_idle", timer_run_n, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
